// File: rtl/ctrl_pkg.sv
// Shared encodings for the CPU control sequencer: state codes, condition codes
// and opcode match constants, plus the opcode classifier used on the latched instruction.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b01,
        ST_EXEC2 = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [3:0]  COND_ALWAYS = 4'b0110;

    localparam logic [3:0]  OP_JMD  = 4'b1100;
    localparam logic [3:0]  OP_CALL = 4'b1101;
    localparam logic [11:0] OP_RTN  = 12'hF00;
    localparam logic [11:0] OP_STP  = 12'hF01;
    localparam logic [8:0]  OP_JMR  = 9'h000;
    localparam logic [8:0]  OP_CAR  = 9'h003;
    localparam logic [8:0]  OP_LDI  = 9'h00A;
    localparam logic [8:0]  OP_AIM  = 9'h00B;
    localparam logic [8:0]  OP_SIM  = 9'h00C;
    localparam logic [5:0]  OP_LOAD = 6'h19;
    localparam logic [5:0]  OP_POP  = 6'h1A;

    typedef struct packed {
        logic jmd;
        logic call;
        logic rtn;
        logic stp;
        logic jmr;
        logic car;
        logic multi;   // op needs the EXEC2 data-RAM cycle
    } op_t;

    function automatic op_t decode_op(input logic [15:0] i);
        op_t o;
        o.jmd   = (i[15:12] == OP_JMD);
        o.call  = (i[15:12] == OP_CALL);
        o.rtn   = (i[15:4]  == OP_RTN);
        o.stp   = (i[15:4]  == OP_STP);
        o.jmr   = (i[15:7]  == OP_JMR);
        o.car   = (i[15:7]  == OP_CAR);
        o.multi = (i[15:7] == OP_LDI) || (i[15:7] == OP_AIM) || (i[15:7] == OP_SIM) ||
                  (i[15:10] == OP_LOAD) || (i[15:10] == OP_POP);
        return o;
    endfunction

endpackage

// File: rtl/ctrl_cond_eval.sv
// Combinational condition evaluation: picks the condition field out of the instruction
// according to its addressing mode and tests it against the status flags.
module ctrl_cond_eval
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [7:0]  status_reg,
    output logic        cond_pass
);

    logic [3:0] code;

    always_comb begin
        code = COND_ALWAYS;
        if (ir[15:11] == 5'b11110) begin
            code = ir[3:0];
        end else if (ir[15:11] == 5'b11111) begin
            code = ir[6:3];
        end else begin
            case (ir[15:14])
                2'b11:   code = COND_ALWAYS;
                2'b10:   code = ir[12:9];
                2'b01:   code = ir[9:6];
                default: code = ir[13] ? ir[10:7] : ir[6:3];
            endcase
        end
    end

    // Code 6 selects the unused flag slot, so both polarities of it mean "always".
    always_comb begin
        if (code[2:0] == 3'd6) cond_pass = 1'b1;
        else                   cond_pass = status_reg[code[2:0]] ^ code[3];
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// CPU control path: fetch/exec1/exec2/halt FSM, PC, instruction latch and return-stack pointer.
// Optional interrupt entry in FETCH is built when CTRL_IRQ_EN is defined.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
`ifdef CTRL_IRQ_EN
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = 'h0004,
`endif
    parameter int STACK_DEPTH = 16,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    input  logic [7:0]        status_reg,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] return_addr,
    input  logic              mem_ready,
`ifdef CTRL_IRQ_EN
    input  logic              irq,
`endif
    output logic [1:0]        state,
    output logic [15:0]       ir,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] pc,
    output logic              cond_pass,
    output logic              stack_push,
    output logic              stack_pop,
    output logic [SP_W-1:0]   sp,
    output logic              stack_err,
    output logic              halted,
    output logic              irq_ack
);

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              rtn_pend_q, rtn_pend_d;
    logic              stack_full, stack_empty;
    op_t               op;
`ifdef CTRL_IRQ_EN
    localparam int     IE_BIT = 7;
    logic              ack_q, ack_d;
`endif

    assign op          = decode_op(ir_q);
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);

    ctrl_cond_eval u_cond (
        .ir         (ir_q),
        .status_reg (status_reg),
        .cond_pass  (cond_pass)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        sp_d       = sp_q;
        err_d      = err_q;
        rtn_pend_d = rtn_pend_q;
        push_d     = 1'b0;
        pop_d      = 1'b0;
`ifdef CTRL_IRQ_EN
        ack_d      = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
`ifdef CTRL_IRQ_EN
                if (irq && status_reg[IE_BIT]) begin
                    if (stack_full) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        push_d = 1'b1;
                        sp_d   = sp_q + SP_W'(1);
                        pc_d   = IRQ_VECTOR;
                        ack_d  = 1'b1;
                    end
                end else
`endif
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                rtn_pend_d = 1'b0;
                // Untaken multi-cycle ops still spend their EXEC2 cycle.
                state_d    = op.multi ? ST_EXEC2 : ST_FETCH;
                if (cond_pass) begin
                    if (op.jmd || op.jmr) begin
                        pc_d = jump_target;
                    end else if (op.call || op.car) begin
                        if (stack_full) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            push_d = 1'b1;
                            sp_d   = sp_q + SP_W'(1);
                            pc_d   = jump_target;
                        end
                    end else if (op.rtn) begin
                        if (stack_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pop_d      = 1'b1;
                            sp_d       = sp_q - SP_W'(1);
                            rtn_pend_d = 1'b1;
                            state_d    = ST_EXEC2;
                        end
                    end else if (op.stp) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_EXEC2: begin
                if (mem_ready) begin
                    state_d    = ST_FETCH;
                    rtn_pend_d = 1'b0;
                    if (rtn_pend_q) pc_d = return_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            sp_q       <= '0;
            err_q      <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            rtn_pend_q <= 1'b0;
`ifdef CTRL_IRQ_EN
            ack_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            rtn_pend_q <= rtn_pend_d;
`ifdef CTRL_IRQ_EN
            ack_q      <= ack_d;
`endif
        end
    end

    assign state      = state_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign sp         = sp_q;
    assign stack_err  = err_q;
    assign stack_push = push_q;
    assign stack_pop  = pop_q;
    assign fetch_req  = (state_q == ST_FETCH);
    assign halted     = (state_q == ST_HALT);
`ifdef CTRL_IRQ_EN
    assign irq_ack    = ack_q;
`else
    assign irq_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: single-instruction vector table, hand sequences for
// multi-cycle corners, and a randomized instruction stream checked against an ISA-level model.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  status_reg;
    logic [15:0] jump_target;
    logic [15:0] return_addr;
    logic        mem_ready;
`ifdef CTRL_IRQ_EN
    logic        irq;
`endif
    logic [1:0]  state;
    logic [15:0] ir;
    logic        fetch_req;
    logic [15:0] pc;
    logic        cond_pass;
    logic        stack_push;
    logic        stack_pop;
    logic [4:0]  sp;
    logic        stack_err;
    logic        halted;
    logic        irq_ack;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .status_reg  (status_reg),
        .jump_target (jump_target),
        .return_addr (return_addr),
        .mem_ready   (mem_ready),
`ifdef CTRL_IRQ_EN
        .irq         (irq),
`endif
        .state       (state),
        .ir          (ir),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .cond_pass   (cond_pass),
        .stack_push  (stack_push),
        .stack_pop   (stack_pop),
        .sp          (sp),
        .stack_err   (stack_err),
        .halted      (halted),
        .irq_ack     (irq_ack)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
`ifdef CTRL_IRQ_EN
        irq = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction from a FETCH negedge; returns EXEC1 cond, the strobes seen in the
    // cycle after EXEC1 and the number of EXEC2 cycles. Ends on the negedge after completion.
    task automatic run_instr(input logic [15:0] i, input logic [7:0] st, input logic [15:0] jt,
                             input logic [15:0] ra, input int stall,
                             output logic c, output logic p, output logic q, output int e2);
        instr = i; instr_valid = 1'b1; status_reg = st;
        jump_target = jt; return_addr = ra; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        c = cond_pass;
        @(negedge clk);
        p = stack_push;
        q = stack_pop;
        e2 = 0;
        while (state == 2'b10 && e2 < 64) begin
            mem_ready = (e2 >= stall);
            e2++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        if (e2 >= 64) chk("exec2_timeout", 32'(e2), 32'(stall + 1));
    endtask

    // Condition rule stated directly from the addressing-mode table.
    function automatic logic model_cond(input logic [15:0] i, input logic [7:0] st);
        logic [3:0] code;
        casez (i[15:11])
            5'b11110: code = i[3:0];
            5'b11111: code = i[6:3];
            5'b11???: code = 4'b0110;
            5'b10???: code = i[12:9];
            5'b01???: code = i[9:6];
            5'b001??: code = i[10:7];
            default:  code = i[6:3];
        endcase
        if (code == 4'b0110 || code == 4'b1110) return 1'b1;
        return code[3] ? ~st[code[2:0]] : st[code[2:0]];
    endfunction

    typedef struct {
        logic [15:0] i;
        logic [7:0]  st;
        logic [15:0] jt;
        int          stall;
        logic        e_cond;
        logic [15:0] e_pc;
        logic [4:0]  e_sp;
        logic        e_halt;
        logic        e_err;
    } vec_t;

    initial begin
        vec_t vt[14];
        logic c, p, q;
        int e2;
        logic [15:0] m_pc;
        int m_sp;
        logic m_halt, m_err;

        instr = '0; status_reg = '0; jump_target = '0; return_addr = '0;
        do_reset();

        // reset state
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_sp", 32'(sp), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);
        chk("rst_strobes", {29'd0, stack_push, stack_pop, irq_ack}, 32'h0);
        chk("rst_fetch_req", 32'(fetch_req), 32'h1);

        vt[0]  = '{16'hC012, 8'h00, 16'h0040, 0, 1'b1, 16'h0040, 5'd0, 1'b0, 1'b0}; // JMD always
        vt[1]  = '{16'h0000, 8'h00, 16'h0040, 0, 1'b0, 16'h0001, 5'd0, 1'b0, 1'b0}; // JMR on Z, Z=0
        vt[2]  = '{16'h0000, 8'h01, 16'h0077, 0, 1'b1, 16'h0077, 5'd0, 1'b0, 1'b0}; // JMR on Z, Z=1
        vt[3]  = '{16'h0040, 8'h00, 16'h0123, 0, 1'b1, 16'h0123, 5'd0, 1'b0, 1'b0}; // JMR on !Z
        vt[4]  = '{16'hD000, 8'h00, 16'h0300, 0, 1'b1, 16'h0300, 5'd1, 1'b0, 1'b0}; // CALL
        vt[5]  = '{16'hF006, 8'h00, 16'h0300, 0, 1'b1, 16'h0001, 5'd0, 1'b1, 1'b1}; // RTN underflow
        vt[6]  = '{16'hF016, 8'h00, 16'h0300, 0, 1'b1, 16'h0001, 5'd0, 1'b1, 1'b0}; // STP taken
        vt[7]  = '{16'hF010, 8'h00, 16'h0300, 0, 1'b0, 16'h0001, 5'd0, 1'b0, 1'b0}; // STP untaken
        vt[8]  = '{16'h0530, 8'h00, 16'h0300, 2, 1'b1, 16'h0001, 5'd0, 1'b0, 1'b0}; // LDI
        vt[9]  = '{16'h6400, 8'h00, 16'h0300, 3, 1'b0, 16'h0001, 5'd0, 1'b0, 1'b0}; // LOAD on Z
        vt[10] = '{16'h01B0, 8'h00, 16'h0500, 0, 1'b1, 16'h0500, 5'd1, 1'b0, 1'b0}; // CAR always
        vt[11] = '{16'h9400, 8'h00, 16'h0300, 0, 1'b1, 16'h0001, 5'd0, 1'b0, 1'b0}; // mode 10, !C
        vt[12] = '{16'h2100, 8'h04, 16'h0300, 0, 1'b1, 16'h0001, 5'd0, 1'b0, 1'b0}; // mode 001, C
        vt[13] = '{16'hF838, 8'h80, 16'h0300, 0, 1'b1, 16'h0001, 5'd0, 1'b0, 1'b0}; // mode 11111, IE
        for (int k = 0; k < 14; k++) begin
            do_reset();
            run_instr(vt[k].i, vt[k].st, vt[k].jt, 16'h0, vt[k].stall, c, p, q, e2);
            chk($sformatf("vec%0d_cond", k), 32'(c), 32'(vt[k].e_cond));
            chk($sformatf("vec%0d_pc", k), 32'(pc), 32'(vt[k].e_pc));
            chk($sformatf("vec%0d_sp", k), 32'(sp), 32'(vt[k].e_sp));
            chk($sformatf("vec%0d_halt", k), 32'(halted), 32'(vt[k].e_halt));
            chk($sformatf("vec%0d_err", k), 32'(stack_err), 32'(vt[k].e_err));
        end

        // JMD: EXEC1 on the next cycle, target in the following FETCH
        do_reset();
        instr = 16'hC0A5; instr_valid = 1'b1; jump_target = 16'h0040; status_reg = 8'h00;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("jmd_exec1", 32'(state), 32'h1);
        chk("jmd_exec1_pc", 32'(pc), 32'h1);
        chk("jmd_ir", 32'(ir), 32'hC0A5);
        @(negedge clk);
        chk("jmd_fetch", 32'(state), 32'h0);
        chk("jmd_pc", 32'(pc), 32'h0040);

        // LOAD held in EXEC2 while mem_ready is low
        do_reset();
        instr = 16'h6580; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("load_hold%0d", n), 32'(state), 32'h2);
            @(negedge clk);
        end
        chk("load_hold_end", 32'(state), 32'h2);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("load_done", 32'(state), 32'h0);
        chk("load_pc", 32'(pc), 32'h1);

        // reset wins over a pending EXEC2
        instr = 16'h6580; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pend_exec2", 32'(state), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_exec2_state", 32'(state), 32'h0);
        chk("rst_exec2_pc", 32'(pc), 32'h0);

        // push strobe timing, then RTN returning through EXEC2
        instr = 16'hD000; instr_valid = 1'b1; jump_target = 16'h0200;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("push_not_in_exec1", 32'(stack_push), 32'h0);
        @(negedge clk);
        chk("push_strobe", 32'(stack_push), 32'h1);
        chk("push_sp", 32'(sp), 32'h1);
        @(negedge clk);
        chk("push_one_cycle", 32'(stack_push), 32'h0);
        run_instr(16'hF006, 8'h00, 16'h0, 16'h1234, 2, c, p, q, e2);
        chk("rtn_pop", 32'(q), 32'h1);
        chk("rtn_exec2", 32'(e2), 32'h3);
        chk("rtn_pc", 32'(pc), 32'h1234);
        chk("rtn_sp", 32'(sp), 32'h0);

        // 16 CALLs fill the stack; the 17th overflows and halts
        do_reset();
        for (int k = 0; k < 16; k++)
            run_instr(16'hD000, 8'h00, 16'h0100 + 16'(k), 16'h0, 0, c, p, q, e2);
        chk("fill_sp", 32'(sp), 32'd16);
        chk("fill_err", 32'(stack_err), 32'h0);
        run_instr(16'hD000, 8'h00, 16'h0900, 16'h0, 0, c, p, q, e2);
        chk("ovf_push", 32'(p), 32'h0);
        chk("ovf_sp", 32'(sp), 32'd16);
        chk("ovf_err", 32'(stack_err), 32'h1);
        chk("ovf_halt", 32'(halted), 32'h1);
        chk("ovf_pc", 32'(pc), 32'h0110);
        instr = 16'hC000; instr_valid = 1'b1; jump_target = 16'h0055;
        repeat (4) @(negedge clk);
        instr_valid = 1'b0;
        chk("halt_sticky", 32'(state), 32'h3);
        chk("halt_pc", 32'(pc), 32'h0110);
        do_reset();
        chk("halt_reset_state", 32'(state), 32'h0);
        chk("halt_reset_err", 32'(stack_err), 32'h0);

`ifdef CTRL_IRQ_EN
        // interrupt beats instr_valid in FETCH; IE=0 masks it
        do_reset();
        status_reg = 8'h80; irq = 1'b1; instr = 16'hC000; instr_valid = 1'b1; jump_target = 16'h0999;
        @(negedge clk);
        irq = 1'b0; instr_valid = 1'b0;
        chk("irq_ack", 32'(irq_ack), 32'h1);
        chk("irq_push", 32'(stack_push), 32'h1);
        chk("irq_pc", 32'(pc), 32'h0004);
        chk("irq_sp", 32'(sp), 32'h1);
        chk("irq_state", 32'(state), 32'h0);
        chk("irq_no_latch", 32'(ir), 32'h0);
        @(negedge clk);
        chk("irq_ack_pulse", 32'(irq_ack), 32'h0);
        status_reg = 8'h00; irq = 1'b1; instr_valid = 1'b1;
        @(negedge clk);
        irq = 1'b0; instr_valid = 1'b0;
        chk("irq_masked_ack", 32'(irq_ack), 32'h0);
        chk("irq_masked_state", 32'(state), 32'h1);
        @(negedge clk);
`endif

        // randomized instruction stream against the ISA-level model
        do_reset();
        m_pc = 16'h0; m_sp = 0; m_halt = 1'b0; m_err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] i, jt, ra;
            logic [7:0]  st;
            int          stall;
            logic        e_cond, e_push, e_pop, e_e2;
            i  = 16'($urandom);
            case ($urandom_range(0, 11))
                0:       i = {4'hC, i[11:0]};
                1, 2, 3: i = {4'hD, i[11:0]};
                4, 5:    i = {12'hF00, i[3:0]};
                6:       i = {12'hF01, i[3:0]};
                7:       i = {9'h000, i[6:0]};
                8:       i = {9'h003, i[6:0]};
                9:       i = {9'h00A + 9'($urandom_range(0, 2)), i[6:0]};
                10:      i = {6'h19 + 6'($urandom_range(0, 1)), i[9:0]};
                default: ;
            endcase
            st = 8'($urandom); jt = 16'($urandom); ra = 16'($urandom);
            stall = $urandom_range(0, 3);

            e_cond = model_cond(i, st);
            e_push = 1'b0; e_pop = 1'b0;
            e_e2 = (i[15:7] >= 9'h00A && i[15:7] <= 9'h00C) || i[15:10] == 6'h19 || i[15:10] == 6'h1A;
            m_pc = m_pc + 16'd1;
            if (e_cond) begin
                if (i[15:12] == 4'hC || i[15:7] == 9'h000) begin
                    m_pc = jt;
                end else if (i[15:12] == 4'hD || i[15:7] == 9'h003) begin
                    if (m_sp == 16) begin m_err = 1'b1; m_halt = 1'b1; end
                    else begin m_sp++; e_push = 1'b1; m_pc = jt; end
                end else if (i[15:4] == 12'hF00) begin
                    if (m_sp == 0) begin m_err = 1'b1; m_halt = 1'b1; end
                    else begin m_sp--; e_pop = 1'b1; e_e2 = 1'b1; m_pc = ra; end
                end else if (i[15:4] == 12'hF01) begin
                    m_halt = 1'b1;
                end
            end

            run_instr(i, st, jt, ra, stall, c, p, q, e2);
            chk($sformatf("rnd%0d_cond i=%h", n, i), 32'(c), 32'(e_cond));
            chk($sformatf("rnd%0d_pc", n), 32'(pc), 32'(m_pc));
            chk($sformatf("rnd%0d_sp", n), 32'(sp), 32'(m_sp));
            chk($sformatf("rnd%0d_err", n), 32'(stack_err), 32'(m_err));
            chk($sformatf("rnd%0d_halt", n), 32'(halted), 32'(m_halt));
            chk($sformatf("rnd%0d_strobes", n), {30'd0, p, q}, {30'd0, e_push, e_pop});
            chk($sformatf("rnd%0d_exec2", n), 32'(e2), e_e2 ? 32'(stall + 1) : 32'h0);
            if (m_halt) begin
                do_reset();
                m_pc = 16'h0; m_sp = 0; m_halt = 1'b0; m_err = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
